// File: rtl/bitty_core_param.sv
// rtl/bitty_core_param.sv - 4-state accumulator core with a small register file.
// Optional macro BITTY_FLAGS_EN builds the {neg, carry, zero} flag register.
module bitty_core_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  input  logic [15:0]                  instruction,
  output logic                         instr_ready,
  output logic                         busy,
  output logic                         done,
  output logic [DATA_W-1:0]            result,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [2:0]                   flags
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

  localparam logic [5:0] DW6 = 6'(DATA_W);

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] s_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [2:0] rx;
  logic [2:0] ry;
  logic [7:0] imm;
  logic [2:0] op;
  logic [1:0] fmt;
  logic       is_nop;

  assign rx     = ir[15:13];
  assign ry     = ir[12:10];
  assign imm    = ir[12:5];
  assign op     = ir[4:2];
  assign fmt    = ir[1:0];
  assign is_nop = fmt[1];

  // Indices past the implemented file read as zero via the default.
  logic [DATA_W-1:0] rx_val;
  logic [DATA_W-1:0] ry_val;
  always_comb begin
    rx_val = '0;
    ry_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rx == 3'(k)) rx_val = regs[k];
      if (ry == 3'(k)) ry_val = regs[k];
    end
  end

  logic [DATA_W-1:0] opb;
  logic [4:0]        shamt;
  assign opb   = fmt[0] ? DATA_W'(imm) : ry_val;
  assign shamt = opb[4:0];

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  always_comb begin
    sum   = '0;
    alu_y = '0;
    alu_c = 1'b0;
    case (op)
      3'd0: begin
        sum   = {1'b0, s_q} + {1'b0, opb};
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      3'd1: begin
        sum   = {1'b0, s_q} - {1'b0, opb};
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      3'd2: alu_y = s_q & opb;
      3'd3: alu_y = s_q | opb;
      3'd4: alu_y = s_q ^ opb;
      3'd5: alu_y = ({1'b0, shamt} >= DW6) ? '0 : (s_q << shamt);
      3'd6: alu_y = ({1'b0, shamt} >= DW6) ? '0 : (s_q >> shamt);
      default: begin
        if (s_q == opb)     alu_y = '0;
        else if (s_q > opb) alu_y = DATA_W'(1);
        else                alu_y = DATA_W'(2);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
      s_q   <= '0;
      c_q   <= '0;
      done  <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instruction;
            state <= LOAD;
          end
        end
        LOAD: begin
          s_q   <= rx_val;
          state <= EXEC;
        end
        EXEC: begin
          if (!is_nop) c_q <= alu_y;
          done  <= 1'b1;
          state <= WB;
        end
        default: begin
          if (!is_nop) begin
            for (int k = 0; k < NUM_REGS; k++)
              if (rx == 3'(k)) regs[k] <= c_q;
          end
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BITTY_FLAGS_EN
  logic [2:0] flags_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 3'b000;
    end else if (state == EXEC && !is_nop) begin
      // Carry is only meaningful for add/sub; other ops clear it.
      flags_q <= {alu_y[DATA_W-1], (op == 3'd0 || op == 3'd1) ? alu_c : 1'b0, alu_y == '0};
    end
  end
  assign flags = flags_q;
`else
  logic carry_unused;
  assign carry_unused = alu_c;
  assign flags = 3'b000;
`endif

  assign instr_ready = (state == IDLE) && !reset;
  assign busy        = (state != IDLE);
  assign result      = c_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
